// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Loads and stores that hit are served in the same cycle. A miss stalls the CPU
// while the FSM writes back a dirty victim, fetches the new block, and installs
// it. The request then completes as a hit.
module dcache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [127:0]          fetch_q, fetch_d;
    logic [127:0]          data_q [LINES];
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  hit_s;
    logic                  wr_req_s;
    logic                  rd_req_s;
    logic                  any_req_s;
    logic                  wr_hit_s;
    logic                  upd_s;
    logic [127:0]          line_s;
    logic [31:0]           word_s;

    // Byte/halfword/word selection and sign/zero extension of a load result.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merge right-aligned store data into a line at the given byte offset.
    function automatic logic [127:0] merge_store(input logic [127:0] line,
                                                 input logic [3:0]   off,
                                                 input logic [1:0]   size,
                                                 input logic [31:0]  data);
        logic [127:0] r;
        r = line;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]            = data[7:0];
            2'b01:   r[{off[3:1], 4'b0000} +: 16]     = data[15:0];
            2'b10:   r[{off[3:2], 5'b00000} +: 32]    = data;
            default: r = line;
        endcase
        return r;
    endfunction

    assign idx_s     = ADDRESS[3+INDEX_BITS:4];
    assign tag_s     = ADDRESS[31:4+INDEX_BITS];
    assign wr_req_s  = WRITE[2];
    assign rd_req_s  = READ[3] & ~WRITE[2];
    assign any_req_s = READ[3] | WRITE[2];
    assign line_s    = data_q[idx_s];
    assign word_s    = line_s[{ADDRESS[3:2], 5'b00000} +: 32];
    assign hit_s     = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    assign wr_hit_s  = (state_q == IDLE) & wr_req_s & hit_s;
    assign upd_s     = (state_q == UPDATE);

    // Load data is only presented for a read hit in IDLE; zero otherwise.
    always_comb begin
        if ((state_q == IDLE) && rd_req_s && hit_s) begin
            READDATA = load_extract(word_s, ADDRESS[1:0], READ[2:0]);
        end else begin
            READDATA = 32'd0;
        end
    end

    // Stall whenever the FSM is busy or a pending request misses in IDLE.
    always_comb begin
        if (state_q != IDLE) begin
            BUSYWAIT = 1'b1;
        end else if (any_req_s && !hit_s) begin
            BUSYWAIT = 1'b1;
        end else begin
            BUSYWAIT = 1'b0;
        end
    end

    // Miss-handling FSM next state and capture of the fetched block.
    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        case (state_q)
            IDLE: begin
                if (any_req_s && !hit_s) begin
                    if (valid_q[idx_s] && dirty_q[idx_s]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = ALLOCATE;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                    fetch_d = MEM_READDATA;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side request signals; all quiet outside WRITEBACK/ALLOCATE.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 28'd0;
        MEM_WRITEDATA = 128'd0;
        case (state_q)
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx_s], idx_s};
                MEM_WRITEDATA = line_s;
            end
            ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
            end
            default: begin
                MEM_READ = 1'b0;
            end
        endcase
    end

    // FSM state, fetch buffer and per-line valid/dirty flags.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            fetch_q <= 128'd0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            if (upd_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Line data and tag storage; invalidated lines are ignored, so no reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (upd_s) begin
                data_q[idx_s] <= fetch_q;
                tag_q[idx_s]  <= tag_s;
            end else if (wr_hit_s) begin
                data_q[idx_s] <= merge_store(line_s, ADDRESS[3:0], WRITE[1:0], WRITEDATA);
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: a small main-memory model with programmable latency and a
// flat byte-array reference of what every load must return.
module tb_dcache;

    logic         CLK;
    logic         RST;
    logic [3:0]   READ;
    logic [2:0]   WRITE;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int errors = 0;

    dcache #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- main memory model (32 blocks = 512 bytes) -------------
    logic [127:0] mem_wr [0:31];
    logic [31:0]  mem_valid;
    logic         mem_clr;
    int           mem_cnt;
    int           lat;

    function automatic logic [127:0] init_block(input int b);
        logic [127:0] r;
        logic [7:0]   bb;
        logic [7:0]   ww;
        bb = 8'(b);
        for (int w = 0; w < 4; w++) begin
            ww = 8'(w);
            r[w*32 +: 32] = {8'hA0 + ww, bb, bb ^ 8'h5C, 8'h30 + ww * 8'h11 + bb};
        end
        if (b == 4) r[31:0] = 32'hDEADBEEF;
        return r;
    endfunction

    always_comb begin
        if (mem_valid[MEM_ADDRESS[4:0]]) MEM_READDATA = mem_wr[MEM_ADDRESS[4:0]];
        else                             MEM_READDATA = init_block(int'(MEM_ADDRESS[4:0]));
    end

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt != lat);

    always @(posedge CLK) begin
        if (mem_clr) begin
            mem_valid <= 32'd0;
            mem_cnt   <= 0;
        end else if (!(MEM_READ | MEM_WRITE)) begin
            mem_cnt <= 0;
        end else if (MEM_BUSYWAIT) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
            if (MEM_WRITE) begin
                mem_wr[MEM_ADDRESS[4:0]]    <= MEM_WRITEDATA;
                mem_valid[MEM_ADDRESS[4:0]] <= 1'b1;
            end
        end
    end

    // ---------------- reference: flat byte-addressed memory -----------------
    logic [7:0] ref_mem [0:511];

    // After a reset the cache holds nothing, so main memory is the truth.
    task automatic ref_sync();
        logic [127:0] blk;
        for (int b = 0; b < 32; b++) begin
            blk = mem_valid[b] ? mem_wr[b] : init_block(b);
            for (int k = 0; k < 16; k++) ref_mem[b*16 + k] = blk[k*8 +: 8];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] addr);
        int a;
        a = int'(addr[8:0]);
        case (f)
            3'b000:  return 32'($signed(ref_mem[a]));
            3'b001:  return 32'($signed({ref_mem[a+1], ref_mem[a]}));
            3'b010:  return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
            3'b100:  return 32'(ref_mem[a]);
            3'b101:  return 32'({ref_mem[a+1], ref_mem[a]});
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] d);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[int'(addr[8:0]) + i] = d[i*8 +: 8];
    endtask

    // ---------------- access driver ----------------------------------------
    logic [31:0]  acc_rdata;
    int           acc_cycles;
    logic         saw_rd, saw_wr;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    // Starts #1 after a rising edge; returns #1 after the completing edge.
    task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic done;
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        saw_rd = 1'b0; saw_wr = 1'b0; rd_addr = 28'd0; wr_addr = 28'd0; wr_data = 128'd0;
        acc_cycles = 0; done = 1'b0; acc_rdata = 32'd0;
        while (!done && acc_cycles < 200) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                acc_rdata = READDATA;
                done = 1'b1;
            end else begin
                if (MEM_READ) begin saw_rd = 1'b1; rd_addr = MEM_ADDRESS; end
                if (MEM_WRITE && !saw_wr) begin
                    saw_wr = 1'b1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA;
                end
            end
            @(posedge CLK); #1;
            acc_cycles++;
        end
        READ = 4'd0; WRITE = 3'd0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_timeout: addr %h still busy after %0d cycles, required completion", addr, acc_cycles);
        end
        if (wr[2]) ref_store(wr[1:0], addr, wd);
    endtask

    task automatic do_reset();
        RST = 1'b0; READ = 4'd0; WRITE = 3'd0; ADDRESS = 32'd0; WRITEDATA = 32'd0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        ref_sync();
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        RST = 1'b0; READ = 4'd0; WRITE = 3'd0; ADDRESS = 32'h40; WRITEDATA = 32'd0;
        @(posedge CLK); #1;
        mem_clr = 1'b0;
        @(negedge CLK);
        checks++;
        if ({READDATA, BUSYWAIT, MEM_READ, MEM_WRITE} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h bw=%b mr=%b mw=%b, required all zero", READDATA, BUSYWAIT, MEM_READ, MEM_WRITE);
        end
        checks++;
        if (MEM_ADDRESS !== 28'd0 || MEM_WRITEDATA !== 128'd0) begin
            errors++;
            $display("FAIL reset_mem_bus: addr=%h data=%h, required zero", MEM_ADDRESS, MEM_WRITEDATA);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        ref_sync();
    endtask

    task automatic test_cold_miss();
        lat = 5;
        access(4'b1010, 3'b000, 32'h40, 32'd0);
        checks++;
        if (!(acc_cycles > 1 && saw_rd && rd_addr == 28'h4 && !saw_wr)) begin
            errors++;
            $display("FAIL cold_miss_traffic: cycles=%0d rd=%b@%h wr=%b, required stall, read @0000004, no write", acc_cycles, saw_rd, rd_addr, saw_wr);
        end
        checks++;
        if (acc_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cold_miss_data: got %h required DEADBEEF", acc_rdata);
        end
    endtask

    task automatic test_write_hit_sign();
        access(4'b0000, 3'b100, 32'h41, 32'h80);
        checks++;
        if (acc_cycles != 1) begin
            errors++;
            $display("FAIL sb_hit_stall: %0d cycles, required 1", acc_cycles);
        end
        access(4'b1000, 3'b000, 32'h41, 32'd0);
        checks++;
        if (acc_rdata !== 32'hFFFFFF80 || acc_cycles != 1) begin
            errors++;
            $display("FAIL lb_sign: got %h in %0d cycles, required FFFFFF80 in 1", acc_rdata, acc_cycles);
        end
        access(4'b1100, 3'b000, 32'h41, 32'd0);
        checks++;
        if (acc_rdata !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_zero: got %h required 00000080", acc_rdata);
        end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] exp;
        exp = ref_load(3'b010, 32'hC0);
        access(4'b1010, 3'b000, 32'hC0, 32'd0);
        checks++;
        if (!(saw_wr && wr_addr == 28'h4 && wr_data[31:0] == 32'hDEAD80EF)) begin
            errors++;
            $display("FAIL evict_writeback: wr=%b addr=%h word0=%h, required write @0000004 word0 DEAD80EF", saw_wr, wr_addr, wr_data[31:0]);
        end
        checks++;
        if (!(saw_rd && rd_addr == 28'hC) || acc_rdata !== exp) begin
            errors++;
            $display("FAIL evict_fill: rd=%b@%h data=%h, required read @000000C data %h", saw_rd, rd_addr, acc_rdata, exp);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: bw=%b mr=%b mw=%b, required 0", BUSYWAIT, MEM_READ, MEM_WRITE);
            end
        end
        @(posedge CLK); #1;
        access(4'b1010, 3'b000, 32'hC0, 32'd0);
        checks++;
        if (acc_cycles != 1 || acc_rdata !== ref_load(3'b010, 32'hC0)) begin
            errors++;
            $display("FAIL idle_retains: %0d cycles data %h, required hit with %h", acc_cycles, acc_rdata, ref_load(3'b010, 32'hC0));
        end
    endtask

    task automatic test_clean_conflict();
        do_reset();
        access(4'b1010, 3'b000, 32'h40, 32'd0);
        checks++;
        if (acc_rdata !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL written_back_data: got %h required DEAD80EF", acc_rdata);
        end
        access(4'b1010, 3'b000, 32'hC0, 32'd0);
        checks++;
        if (!saw_rd || saw_wr) begin
            errors++;
            $display("FAIL clean_conflict: rd=%b wr=%b, required read only", saw_rd, saw_wr);
        end
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        lat = 5;
        READ = 4'b1010; ADDRESS = 32'h40;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (MEM_READ !== 1'b1) begin
            errors++;
            $display("FAIL mid_miss_alloc: mem_read=%b required 1", MEM_READ);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_req: mr=%b mw=%b required 0", MEM_READ, MEM_WRITE);
        end
        RST = 1'b1; READ = 4'd0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        ref_sync();
        access(4'b1010, 3'b000, 32'h40, 32'd0);
        checks++;
        if (acc_cycles == 1 || !saw_rd || acc_rdata !== ref_load(3'b010, 32'h40)) begin
            errors++;
            $display("FAIL remiss_after_reset: cycles=%0d rd=%b data=%h, required miss with %h", acc_cycles, saw_rd, acc_rdata, ref_load(3'b010, 32'h40));
        end
    endtask

    task automatic test_read_write_same();
        access(4'b1010, 3'b110, 32'h40, 32'h12345678);
        checks++;
        if (acc_cycles != 1) begin
            errors++;
            $display("FAIL rw_hit_stall: %0d cycles, required 1", acc_cycles);
        end
        access(4'b1010, 3'b000, 32'h40, 32'd0);
        checks++;
        if (acc_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rw_store_done: got %h required 12345678", acc_rdata);
        end
        access(4'b1001, 3'b000, 32'h42, 32'd0);
        checks++;
        if (acc_rdata !== 32'h00001234) begin
            errors++;
            $display("FAIL lh_upper: got %h required 00001234", acc_rdata);
        end
    endtask

    task automatic test_random();
        logic [2:0]  ftab [5];
        logic [2:0]  f;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp;
        int          kind;
        ftab[0] = 3'b000; ftab[1] = 3'b001; ftab[2] = 3'b010; ftab[3] = 3'b100; ftab[4] = 3'b101;
        for (int i = 0; i < 300; i++) begin
            lat  = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            a    = 32'($urandom_range(0, 511));
            wd   = $urandom;
            if (kind == 0) begin
                f = ftab[$urandom_range(0, 4)];
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
                exp = ref_load(f, a);
                access({1'b1, f}, 3'b000, a, 32'd0);
                checks++;
                if (acc_rdata !== exp) begin
                    errors++;
                    $display("FAIL random_load: op %0d f=%b addr %h got %h required %h", i, f, a, acc_rdata, exp);
                end
            end else begin
                sz = 2'($urandom_range(0, 2));
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
                access((kind == 2) ? 4'b1010 : 4'b0000, {1'b1, sz}, a, wd);
            end
        end
        for (int b = 0; b < 128; b++) begin
            a = 32'(b * 4);
            exp = ref_load(3'b010, a);
            access(4'b1010, 3'b000, a, 32'd0);
            checks++;
            if (acc_rdata !== exp) begin
                errors++;
                $display("FAIL sweep_load: addr %h got %h required %h", a, acc_rdata, exp);
            end
        end
    endtask

    initial begin
        mem_clr = 1'b1;
        lat = 5;
        test_reset();
        test_cold_miss();
        test_write_hit_sign();
        test_dirty_evict();
        test_idle();
        test_clean_conflict();
        test_reset_mid_miss();
        test_read_write_same();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
